// File: rtl/mmu_fifo_feed_ctrl_pkg.sv
// Shared definitions for the MMU row-FIFO feed controller: state encoding and
// default array geometry, also used by whoever instantiates the row FIFOs.
package mmu_feed_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_LOAD  = LOAD,
    ST_DRAIN = DRAIN,
    ST_DONE  = DONE
  } feed_state_e;

  localparam int FEED_ROWS  = 8;
  localparam int FEED_DEPTH = 70;

endpackage

// File: rtl/mmu_fifo_feed_ctrl_if.sv
// Control bundle between the feed controller and its surroundings (operand
// buffer handshake, row-FIFO flags/enables, array valids and status).
// The err_o flag exists only when MMU_FEED_CHECK_EN is defined.
interface mmu_fifo_feed_ctrl_if #(
  parameter int ROWS  = mmu_feed_pkg::FEED_ROWS,
  parameter int DEPTH = mmu_feed_pkg::FEED_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + ROWS)
) ();

  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [ROWS-1:0]  fifo_full_i;
  logic [ROWS-1:0]  fifo_empty_i;
  logic [ROWS-1:0]  fifo_wren_o;
  logic [ROWS-1:0]  fifo_rden_o;
  logic [ROWS-1:0]  row_valid_o;
  logic             hold_i;
  logic             busy_o;
  logic             done_o;

`ifdef MMU_FEED_CHECK_EN
  logic             err_o;

  modport master (
    output start_i, len_i, in_valid_i, fifo_full_i, fifo_empty_i, hold_i,
    input  in_ready_o, fifo_wren_o, fifo_rden_o, row_valid_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, len_i, in_valid_i, fifo_full_i, fifo_empty_i, hold_i,
    output in_ready_o, fifo_wren_o, fifo_rden_o, row_valid_o, busy_o, done_o, err_o
  );
`else
  modport master (
    output start_i, len_i, in_valid_i, fifo_full_i, fifo_empty_i, hold_i,
    input  in_ready_o, fifo_wren_o, fifo_rden_o, row_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, len_i, in_valid_i, fifo_full_i, fifo_empty_i, hold_i,
    output in_ready_o, fifo_wren_o, fifo_rden_o, row_valid_o, busy_o, done_o
  );
`endif

endinterface

// File: rtl/mmu_fifo_feed_ctrl_skew_decode.sv
// Row-skew read-enable decoder: row r reads while r <= d < r+len, so each row
// starts one cycle after the row above it. Hold blanks every row at once.
module mmu_skew_decode #(
  parameter int ROWS  = mmu_feed_pkg::FEED_ROWS,
  parameter int CNT_W = 7
) (
  input  logic [CNT_W-1:0] d_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             hold_i,
  output logic [ROWS-1:0]  rden_o
);

  localparam int EW = CNT_W + 1;

  logic [EW-1:0] dExt;
  logic [EW-1:0] lenExt;

  assign dExt   = {1'b0, d_i};
  assign lenExt = {1'b0, len_i};

  // Window compare per row, done one bit wider so r+len cannot wrap.
  always_comb begin
    rden_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      rden_o[r] = !hold_i && (dExt >= EW'(r)) && (dExt < (EW'(r) + lenExt));
    end
  end

endmodule

// File: rtl/mmu_fifo_feed_ctrl.sv
// MMU input-FIFO feed sequencer. Per tile: LOAD writes len beats into every
// row FIFO in parallel, then DRAIN issues row-skewed read enables to the
// systolic array. Only enables/valids are produced; data bypasses this block.
// Optional checker: define MMU_FEED_CHECK_EN to add the sticky err_o flag.
module mmu_fifo_feed_ctrl
  import mmu_feed_pkg::*;
#(
  parameter int ROWS  = FEED_ROWS,
  parameter int DEPTH = FEED_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  mmu_fifo_feed_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ROWS_M2_C = CNT_W'(ROWS - 2);

  feed_state_e      state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] d_q, d_d;

  logic [ROWS-1:0]  rdenDec;
  logic [ROWS-1:0]  wren;
  logic [ROWS-1:0]  rden;
  logic             ready;
  logic             handshake;
  logic             done;
  logic [CNT_W-1:0] lastD;

  // Final drain index: the last row finishes its len reads at d = len+ROWS-2.
  assign lastD = len_q + ROWS_M2_C;

  mmu_skew_decode #(
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_skew (
    .d_i    (d_q),
    .len_i  (len_q),
    .hold_i (bus.hold_i),
    .rden_o (rdenDec)
  );

  // State and counter registers; reset aborts any tile in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  // Next-state and output decode for the LOAD/DRAIN tile sequence.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    ready     = 1'b0;
    handshake = 1'b0;
    wren      = '0;
    rden      = '0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          len_d   = (bus.len_i > DEPTH_C) ? DEPTH_C : bus.len_i;
          cnt_d   = '0;
          d_d     = '0;
          state_d = (bus.len_i == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready     = !(|bus.fifo_full_i);
        handshake = bus.in_valid_i && ready;
        if (handshake) begin
          wren  = '1;
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == len_q) begin
            state_d = ST_DRAIN;
            d_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        rden = rdenDec;
        if (!bus.hold_i) begin
          d_d = d_q + 1'b1;
          if (d_q == lastD) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready_o  = ready;
  assign bus.fifo_wren_o = wren;
  assign bus.fifo_rden_o = rden;
  assign bus.row_valid_o = rden;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done;

`ifdef MMU_FEED_CHECK_EN
  logic err_q;
  logic errEvent;

  assign errEvent = (|(rden & bus.fifo_empty_i))
                  || ((|wren) && (|bus.fifo_full_i))
                  || ((state_q == ST_IDLE) && bus.start_i && (bus.len_i > DEPTH_C));

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (errEvent) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  logic unused_empty;
  assign unused_empty = ^bus.fifo_empty_i;
`endif

endmodule

// File: tb/tb_mmu_fifo_feed_ctrl.sv
// Self-checking bench for mmu_fifo_feed_ctrl with ROWS=4.
// Table vectors are pushed to a scoreboard queue when driven and popped when
// the outputs are sampled; multi-cycle corners use hand-written sequences.
module tb_mmu_fifo_feed_ctrl;
  import mmu_feed_pkg::*;

  localparam int ROWS  = 4;
  localparam int DEPTH = FEED_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + ROWS);

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  mmu_fifo_feed_ctrl_if #(.ROWS(ROWS), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mmu_fifo_feed_ctrl #(.ROWS(ROWS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] len;
    logic             valid;
    logic [ROWS-1:0]  full;
    logic             hold;
    logic             expReady;
    logic [ROWS-1:0]  expWren;
    logic [ROWS-1:0]  expRden;
    logic             expBusy;
    logic             expDone;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  function automatic vec_t mk(input logic st, input int len, input logic vld,
                              input logic [ROWS-1:0] full, input logic hold,
                              input logic rdy, input logic wr,
                              input logic [ROWS-1:0] rd, input logic busy,
                              input logic done);
    vec_t v;
    v.start    = st;
    v.len      = CNT_W'(len);
    v.valid    = vld;
    v.full     = full;
    v.hold     = hold;
    v.expReady = rdy;
    v.expWren  = {ROWS{wr}};
    v.expRden  = rd;
    v.expBusy  = busy;
    v.expDone  = done;
    return v;
  endfunction

  task automatic checkField(input string nm, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    bus.start_i     = v.start;
    bus.len_i       = v.len;
    bus.in_valid_i  = v.valid;
    bus.fifo_full_i = v.full;
    bus.hold_i      = v.hold;
    sbq.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checkField("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      checkField("in_ready", idx, 32'(bus.in_ready_o), 32'(e.expReady));
      checkField("wren", idx, 32'(bus.fifo_wren_o), 32'(e.expWren));
      checkField("rden", idx, 32'(bus.fifo_rden_o), 32'(e.expRden));
      checkField("row_valid", idx, 32'(bus.row_valid_o), 32'(e.expRden));
      checkField("busy", idx, 32'(bus.busy_o), 32'(e.expBusy));
      checkField("done", idx, 32'(bus.done_o), 32'(e.expDone));
    end
  endtask

  // One full tile with in_valid held high; tallies enables per cycle and the
  // cycle index (start cycle = 0) on which done_o appears, -1 if it never does.
  task automatic runTile(input int lenIn, input int bound, output int wrCyc,
                         output int r0Cyc, output int rLastCyc, output int doneCyc);
    wrCyc = 0; r0Cyc = 0; rLastCyc = 0; doneCyc = -1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b1; bus.len_i = CNT_W'(lenIn); bus.in_valid_i = 1'b1;
    bus.hold_i = 1'b0; bus.fifo_full_i = '0;
    @(negedge clk);
    if (bus.fifo_wren_o == {ROWS{1'b1}}) wrCyc++;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (bus.fifo_wren_o == {ROWS{1'b1}}) wrCyc++;
      if (bus.fifo_rden_o[0]) r0Cyc++;
      if (bus.fifo_rden_o[ROWS-1]) rLastCyc++;
      if (bus.done_o) begin
        doneCyc = c;
        break;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    int wr, r0, rl, dc;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.len_i = '0; bus.in_valid_i = 1'b0;
    bus.fifo_full_i = '0; bus.fifo_empty_i = '0; bus.hold_i = 1'b0;

    // Reset state
    #8;
    checkField("rst_busy", 0, 32'(bus.busy_o), 32'd0);
    checkField("rst_done", 0, 32'(bus.done_o), 32'd0);
    checkField("rst_ready", 0, 32'(bus.in_ready_o), 32'd0);
    checkField("rst_wren", 0, 32'(bus.fifo_wren_o), 32'd0);
    checkField("rst_rden", 0, 32'(bus.fifo_rden_o), 32'd0);
`ifdef MMU_FEED_CHECK_EN
    checkField("rst_err", 0, 32'(bus.err_o), 32'd0);
`endif
    #4;
    rst = 1'b0;

    // Basic len=3 tile; a start during DRAIN must be ignored
    vecs.push_back(mk(1, 3, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 0, 4'b0011, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0111, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // len=3 with a 2-cycle hold on the second DRAIN cycle
    vecs.push_back(mk(1, 3, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0111, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // len=2 with row 2 full for 3 cycles and an idle-valid gap
    vecs.push_back(mk(1, 2, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0100, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0100, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0100, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // len=0 goes straight to DONE with no enables
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Reset in DRAIN at d=2
    applyStimulus(mk(1, 3, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0)); checkOutput(100);
    applyStimulus(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0)); checkOutput(101);
    applyStimulus(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0)); checkOutput(102);
    applyStimulus(mk(0, 0, 1, 4'b0000, 0, 1, 1, 4'b0000, 1, 0)); checkOutput(103);
    applyStimulus(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 1, 0)); checkOutput(104);
    applyStimulus(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0)); checkOutput(105);
    applyStimulus(mk(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0111, 1, 0)); checkOutput(106);
    #2;
    rst = 1'b1;
    #1;
    checkField("midrst_rden", 107, 32'(bus.fifo_rden_o), 32'd0);
    checkField("midrst_valid", 107, 32'(bus.row_valid_o), 32'd0);
    checkField("midrst_busy", 107, 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    checkField("postrst_busy", 108, 32'(bus.busy_o), 32'd0);

    // Next tile after reset is accepted normally
    runTile(1, 20, wr, r0, rl, dc);
    checkField("len1_wren_cycles", 109, 32'(wr), 32'd1);
    checkField("len1_row0_reads", 109, 32'(r0), 32'd1);
    checkField("len1_rowlast_reads", 109, 32'(rl), 32'd1);
    checkField("len1_done_cycle", 109, 32'(dc), 32'(1 + 1 + ROWS));

`ifdef MMU_FEED_CHECK_EN
    @(negedge clk);
    checkField("err_before_clamp", 110, 32'(bus.err_o), 32'd0);
`endif

    // Oversized len is clamped to DEPTH
    runTile(DEPTH + 1, 400, wr, r0, rl, dc);
    checkField("clamp_wren_cycles", 111, 32'(wr), 32'(DEPTH));
    checkField("clamp_row0_reads", 111, 32'(r0), 32'(DEPTH));
    checkField("clamp_rowlast_reads", 111, 32'(rl), 32'(DEPTH));
    checkField("clamp_done_cycle", 111, 32'(dc), 32'(1 + DEPTH + DEPTH + ROWS - 1));

`ifdef MMU_FEED_CHECK_EN
    @(negedge clk);
    checkField("err_sticky", 112, 32'(bus.err_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkField("err_cleared", 113, 32'(bus.err_o), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
